// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the ID/EX stages and the pipeline sequencer.
// Latency: n/a (wires only); requests and stall/flush responses share one cycle.
// Backpressure: the stall vector is the backpressure; requesters never wait on a handshake.
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    // Requests from the ID and EX stages
    logic             i_idStallReq;
    logic             i_exMultiStart;
    logic             i_flushReq;
    logic             i_clearCount;

    // Sequencing controls back to the pipeline registers
    logic [4:0]       o_stall;
    logic             o_flush;
    logic             o_exBusy;
    logic [CNT_W-1:0] o_stallCycles;

    // Pipeline side: raises requests, consumes stall/flush
    modport master (
        output i_idStallReq,
        output i_exMultiStart,
        output i_flushReq,
        output i_clearCount,
        input  o_stall,
        input  o_flush,
        input  o_exBusy,
        input  o_stallCycles
    );

    // Controller side
    modport slave (
        input  i_idStallReq,
        input  i_exMultiStart,
        input  i_flushReq,
        input  i_clearCount,
        output o_stall,
        output o_flush,
        output o_exBusy,
        output o_stallCycles
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: per-register stall bits, IF_ID/ID_EX flush, stall-cycle counter.
// Latency: stall/flush are combinational (zero-cycle); o_stallCycles updates on the ending edge.
// Backpressure: holds PC..ID_EX while EX runs a multi-cycle op; PC/IF_ID on an ID hazard.
module pipe_ctrl #(
    parameter int MULTI_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic      i_clk,
    input  logic      i_rstn,
    pipe_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MULTI = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Hold PC and IF_ID; ID_EX takes a bubble
    localparam logic [4:0] STALL_ID   = 5'b00011;
    // Hold PC, IF_ID and ID_EX while EX is occupied; EX_MEM takes a bubble
    localparam logic [4:0] STALL_EX   = 5'b00111;
    localparam logic [4:0] STALL_NONE = 5'b00000;

    // A one-cycle "multi-cycle" op is just a normal EX op
    localparam bit         MULTI_EN   = (MULTI_CYCLES > 1);
    // Remaining MULTI cycles after the start cycle
    localparam logic [2:0] MULTI_LOAD = 3'(MULTI_CYCLES - 1);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       cnt_q;
    logic [2:0]       cnt_d;
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] stall_cycles_d;

    logic [4:0]       stall;
    logic             flush;
    logic             ex_busy;

    // Next state and combinational controls; flush beats multi-cycle beats ID hazard
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = STALL_NONE;
        flush   = 1'b0;
        ex_busy = 1'b0;

        case (state_q)
            RUN: begin
                if (bus.i_flushReq) begin
                    flush   = 1'b1;
                    state_d = FLUSH;
                end else if (bus.i_exMultiStart && MULTI_EN) begin
                    stall   = STALL_EX;
                    cnt_d   = MULTI_LOAD;
                    state_d = MULTI;
                end else if (bus.i_idStallReq) begin
                    stall   = STALL_ID;
                end
            end

            MULTI: begin
                // ID hazards and new multi-cycle starts are meaningless while EX is held
                ex_busy = 1'b1;
                if (bus.i_flushReq) begin
                    // Redirect aborts the op; the wrong-path result is never written back
                    flush   = 1'b1;
                    cnt_d   = 3'd0;
                    state_d = FLUSH;
                end else if (cnt_q > 3'd1) begin
                    stall   = STALL_EX;
                    cnt_d   = cnt_q - 3'd1;
                end else begin
                    // Last EX cycle: result advances, front end released
                    cnt_d   = 3'd0;
                    state_d = RUN;
                end
            end

            FLUSH: begin
                // One quiet cycle while the redirected fetch arrives; only a new redirect counts
                if (bus.i_flushReq) begin
                    flush   = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end

            default: begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end
        endcase

        // Outputs are forced quiet while reset is held, whatever the inputs do
        if (!i_rstn) begin
            stall   = STALL_NONE;
            flush   = 1'b0;
            ex_busy = 1'b0;
        end
    end

    // Stall-cycle counter: clear wins, otherwise count PC-stall cycles up to all-ones
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (bus.i_clearCount) begin
            stall_cycles_d = '0;
        end else if (stall[0] && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + CNT_ONE;
        end
    end

    // Sequencer state, down-counter and performance counter
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q        <= RUN;
            cnt_q          <= 3'd0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.o_stall       = stall;
    assign bus.o_flush       = flush;
    assign bus.o_exBusy      = ex_busy;
    assign bus.o_stallCycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, reset/saturation sequences, random vs. reference model.
// Latency: checks combinational outputs mid-cycle and the counter just after each rising edge.
// Backpressure: n/a; the bench drives requests freely every cycle.
module tb_pipe_ctrl;

    localparam int MC   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic i_clk = 1'b0;
    logic i_rstn;

    always #5 i_clk = ~i_clk;

    pipe_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_ctrl #(
        .MULTI_CYCLES(MC),
        .CNT_W       (CW)
    ) dut (
        .i_clk (i_clk),
        .i_rstn(i_rstn),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: EX occupancy in remaining cycles, whether the previous cycle
    // flushed, and the plain integer stall count.
    int m_left;
    bit m_post_flush;
    int m_cnt;

    typedef struct {
        bit         id;
        bit         mu;
        bit         fl;
        bit         clr;
        logic [4:0] s;
        bit         f;
        bit         b;
        int         ec;     // expected counter after the edge, -1 = not listed
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_left       = 0;
        m_post_flush = 0;
        m_cnt        = 0;
    endtask

    // Expected outputs for this cycle from the behavioural rules
    task automatic model_out(input bit id, input bit mu, input bit fl,
                             output logic [4:0] s, output bit f, output bit b);
        s = 5'b00000;
        f = 1'b0;
        b = 1'b0;
        if (m_post_flush) begin
            f = fl;
        end else if (m_left > 0) begin
            b = 1'b1;
            if (fl)              f = 1'b1;
            else if (m_left > 1) s = 5'b00111;
        end else if (fl) begin
            f = 1'b1;
        end else if (mu && MC > 1) begin
            s = 5'b00111;
        end else if (id) begin
            s = 5'b00011;
        end
    endtask

    // Advance model across one rising edge
    task automatic model_adv(input bit mu, input bit clr,
                             input logic [4:0] s, input bit f, input bit b);
        bit pf;
        pf = m_post_flush;
        if (clr)                         m_cnt = 0;
        else if (s[0] && m_cnt < CMAX)   m_cnt = m_cnt + 1;
        m_post_flush = f;
        if (f)                           m_left = 0;
        else if (b)                      m_left = m_left - 1;
        else if (!pf && mu && MC > 1)    m_left = MC - 1;
    endtask

    // One clock cycle: drive, check outputs mid-cycle, step across the edge, check counter
    task automatic cycle(input bit id, input bit mu, input bit fl, input bit clr,
                         input bit use_tbl, input logic [4:0] es, input bit ef, input bit eb,
                         input int ec, input string tag);
        logic [4:0] s;
        bit f;
        bit b;
        bus.i_idStallReq   = id;
        bus.i_exMultiStart = mu;
        bus.i_flushReq     = fl;
        bus.i_clearCount   = clr;
        #3;
        model_out(id, mu, fl, s, f, b);
        if (use_tbl) begin
            chk({tag, ".stall"}, bus.o_stall,  es);
            chk({tag, ".flush"}, bus.o_flush,  ef);
            chk({tag, ".busy"},  bus.o_exBusy, eb);
        end else begin
            chk({tag, ".stall"}, bus.o_stall,  s);
            chk({tag, ".flush"}, bus.o_flush,  f);
            chk({tag, ".busy"},  bus.o_exBusy, b);
        end
        @(posedge i_clk);
        model_adv(mu, clr, s, f, b);
        #1;
        chk({tag, ".cnt"}, bus.o_stallCycles, m_cnt);
        if (ec >= 0) chk({tag, ".cnt_tbl"}, bus.o_stallCycles, ec);
    endtask

    task automatic add(input bit id, input bit mu, input bit fl, input bit clr,
                       input logic [4:0] s, input bit f, input bit b, input int ec);
        vec_t v;
        v.id = id; v.mu = mu; v.fl = fl; v.clr = clr;
        v.s = s; v.f = f; v.b = b; v.ec = ec;
        tbl.push_back(v);
    endtask

    initial begin
        // id mu fl clr | stall flush busy | counter after edge
        add(0,0,0,0, 5'b00000,0,0, 0);
        add(1,0,0,0, 5'b00011,0,0, 1);
        add(1,0,0,0, 5'b00011,0,0, 2);
        add(0,0,0,0, 5'b00000,0,0, 2);
        // multi-cycle op, ID hazard ignored in MULTI
        add(0,1,0,0, 5'b00111,0,0, 3);
        add(0,0,0,0, 5'b00111,0,1, 4);
        add(1,0,0,0, 5'b00111,0,1, 5);
        add(0,1,0,0, 5'b00000,0,1, 5);
        add(0,0,0,0, 5'b00000,0,0, 5);
        // flush beats everything, FLUSH ignores hazard
        add(1,1,1,0, 5'b00000,1,0, 5);
        add(1,0,0,0, 5'b00000,0,0, 5);
        add(1,0,0,0, 5'b00011,0,0, 6);
        add(0,0,0,0, 5'b00000,0,0, 6);
        // flush on second MULTI cycle
        add(0,1,0,0, 5'b00111,0,0, 7);
        add(0,0,0,0, 5'b00111,0,1, 8);
        add(0,0,1,0, 5'b00000,1,1, 8);
        add(1,0,0,0, 5'b00000,0,0, 8);
        add(0,0,0,0, 5'b00000,0,0, 8);
        // back-to-back multi ops, then hazard after MULTI
        add(0,1,0,0, 5'b00111,0,0, 9);
        add(0,0,0,0, 5'b00111,0,1, 10);
        add(0,0,0,0, 5'b00111,0,1, 11);
        add(0,0,0,0, 5'b00000,0,1, 11);
        add(0,1,0,0, 5'b00111,0,0, 12);
        add(0,0,0,0, 5'b00111,0,1, 13);
        add(0,0,0,0, 5'b00111,0,1, 14);
        add(1,0,0,0, 5'b00000,0,1, 14);
        add(1,0,0,0, 5'b00011,0,0, 15);
        add(1,0,0,0, 5'b00011,0,0, 15);
        add(0,0,0,1, 5'b00000,0,0, 0);
        // consecutive redirects
        add(0,0,1,0, 5'b00000,1,0, 0);
        add(0,1,1,0, 5'b00000,1,0, 0);
        add(1,1,0,0, 5'b00000,0,0, 0);
        add(1,0,0,0, 5'b00011,0,0, 1);
        add(0,0,0,0, 5'b00000,0,0, 1);

        bus.i_idStallReq   = 1'b1;
        bus.i_exMultiStart = 1'b1;
        bus.i_flushReq     = 1'b1;
        bus.i_clearCount   = 1'b0;
        i_rstn             = 1'b0;
        model_reset();

        // Reset holds outputs quiet despite active requests
        #12;
        chk("rst.stall", bus.o_stall,       0);
        chk("rst.flush", bus.o_flush,       0);
        chk("rst.busy",  bus.o_exBusy,      0);
        chk("rst.cnt",   bus.o_stallCycles, 0);
        bus.i_idStallReq   = 1'b0;
        bus.i_exMultiStart = 1'b0;
        bus.i_flushReq     = 1'b0;
        @(negedge i_clk);
        i_rstn = 1'b1;
        @(posedge i_clk);
        #1;

        foreach (tbl[k])
            cycle(tbl[k].id, tbl[k].mu, tbl[k].fl, tbl[k].clr, 1'b1,
                  tbl[k].s, tbl[k].f, tbl[k].b, tbl[k].ec, $sformatf("vec%0d", k));

        // Saturation: 20 stall cycles from near-zero land on all-ones
        for (int i = 0; i < 20; i++)
            cycle(1, 0, 0, 0, 1'b0, 5'b0, 0, 0, -1, "sat");
        chk("sat.final", bus.o_stallCycles, CMAX);
        cycle(1, 0, 0, 1, 1'b1, 5'b00011, 0, 0, 0, "clr_wins");

        // Asynchronous reset in the middle of a multi-cycle op
        cycle(0, 1, 0, 0, 1'b1, 5'b00111, 0, 0, -1, "mrst_start");
        bus.i_idStallReq   = 1'b1;
        bus.i_exMultiStart = 1'b1;
        bus.i_flushReq     = 1'b1;
        #2;
        i_rstn = 1'b0;
        #1;
        chk("mrst.stall", bus.o_stall,       0);
        chk("mrst.flush", bus.o_flush,       0);
        chk("mrst.busy",  bus.o_exBusy,      0);
        chk("mrst.cnt",   bus.o_stallCycles, 0);
        model_reset();
        bus.i_idStallReq   = 1'b0;
        bus.i_exMultiStart = 1'b0;
        bus.i_flushReq     = 1'b0;
        @(negedge i_clk);
        i_rstn = 1'b1;
        @(posedge i_clk);
        #1;
        cycle(1, 0, 0, 0, 1'b1, 5'b00011, 0, 0, 1, "mrst_run");

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0),
                  1'b0, 5'b0, 0, 0, -1, "rnd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage core. It collects hazard, multi-cycle-execute and redirect requests from the ID and EX stages and drives one stall bit per pipeline register plus a flush strobe. The stall vector feeds the PC register and the IF_ID, ID_EX, EX_MEM and MEM_WB registers; the flush strobe clears IF_ID and ID_EX. It also keeps a saturating stall-cycle performance counter.

## Interface
- MULTI_CYCLES, 4, number of cycles a multi-cycle EX operation (mult/div) occupies EX; legal 1..8
- CNT_W, 16, width of the stall-cycle counter
- i_clk  in  1  clock; all state updates on the rising edge
- i_rstn  in  1  asynchronous, active-low reset
- i_idStallReq  in  1  ID load-use or data hazard; combinational from ID this cycle
- i_exMultiStart  in  1  EX holds a multi-cycle op in its first EX cycle
- i_flushReq  in  1  EX redirect (taken branch/jump); single-cycle pulse
- i_clearCount  in  1  synchronous clear of o_stallCycles
- o_stall  out  5  bit0 PC, bit1 IF_ID, bit2 ID_EX, bit3 EX_MEM, bit4 MEM_WB; 1 = hold register
- o_flush  out  1  clear IF_ID and ID_EX to NOP this cycle
- o_exBusy  out  1  EX is inside a multi-cycle op (MULTI state)
- o_stallCycles  out  CNT_W  cycles with o_stall[0]=1, saturating

## Operation
- Stall encoding: stage register i holds when o_stall[i]=1. When o_stall[i]=1 and o_stall[i+1]=0, register i+1 loads a bubble (NOP, dest REG_ZERO).
- States: RUN, MULTI, FLUSH. The down-counter cnt is 3 bits wide.
- Priority in every state: flush > multi-cycle > ID hazard.
- RUN:
  - i_flushReq=1: o_flush=1, o_stall=0, next FLUSH.
  - else i_exMultiStart=1 and MULTI_CYCLES>1: o_stall=5'b00111, cnt<=MULTI_CYCLES-1, next MULTI.
  - else i_idStallReq=1: o_stall=5'b00011 (bubble into ID_EX), stay RUN.
  - else o_stall=0.
  - MULTI_CYCLES=1: i_exMultiStart has no effect.
- MULTI: o_exBusy=1; i_idStallReq and i_exMultiStart are ignored.
  - cnt>1: o_stall=5'b00111, cnt decrements.
  - cnt==1: o_stall=0 (EX result advances), next RUN.
  - i_flushReq=1: aborts the op. o_flush=1, o_stall=0, cnt<=0, next FLUSH.
- FLUSH: lasts exactly one cycle. o_stall=0, o_flush=0, o_exBusy=0. All requests are ignored except i_flushReq, which re-asserts o_flush and stays in FLUSH. Otherwise next RUN.
- Counter:
  - Increments by 1 on each edge where o_stall[0]=1.
  - Saturates at all-ones.
  - i_clearCount=1 loads 0; clear wins over a simultaneous increment.
- o_stall, o_flush and o_exBusy are combinational from state, cnt and inputs. o_stallCycles is a register.

## Timing
- Reset (i_rstn=0, any time, including mid-MULTI):
  - state=RUN, cnt=0, o_stallCycles=0.
  - o_stall=0, o_flush=0, o_exBusy=0 regardless of inputs.
  - Operation resumes on the first rising edge after deassertion.
- Zero-cycle response in RUN: ID hazard stall and flush appear in the same cycle as the request.
- Multi-cycle op: EX is occupied for MULTI_CYCLES cycles, and o_stall[0] is high for MULTI_CYCLES-1 consecutive cycles (start cycle plus MULTI cycles with cnt>1).
- A hazard re-presented by ID after MULTI ends is honoured normally in the following RUN cycle.
- Back-to-back multi-cycle ops: an i_exMultiStart in the first RUN cycle after MULTI restarts the sequence with no gap cycle.
- o_stallCycles reflects a stall on the edge that ends the stalled cycle (one-cycle latency).

## Test plan
- Reset then idle: all outputs 0 → i_idStallReq=1 for 2 cycles → o_stall=5'b00011 both cycles, o_stallCycles=2 afterwards.
- MULTI_CYCLES=4, i_exMultiStart pulse → o_stall=5'b00111 for 3 cycles, o_exBusy=1 for 3 cycles (MULTI), then o_stall=0; o_stallCycles=3.
- i_flushReq together with i_exMultiStart and i_idStallReq in RUN → o_flush=1, o_stall=0, next cycle FLUSH ignores i_idStallReq=1 (o_stall=0), then RUN.
- i_flushReq on second MULTI cycle → o_flush=1 that cycle, o_exBusy=0 next, no further stall cycles.
- Preload counter near saturation (CNT_W=4): 20 stall cycles → o_stallCycles=15; i_clearCount with i_idStallReq=1 → 0.
- Assert i_rstn=0 mid-MULTI → outputs 0 immediately (asynchronous), state RUN after release, o_stallCycles=0.
